output_buffer_reader: RTL and testbench

- Downstream drain engine for the RRAM controller output buffer.
- Accepts a host command (start address, word count) and drives the buffer's read-side address/chip-select/enable.
- Absorbs the buffer's 2-cycle read pipeline and presents the words on a valid/ready stream with a last marker.
- Sits between the output buffer read port and the host interface block.

---
 rtl/output_buffer_reader.sv | 180 ++++++++++++++++++
 tb/tb_output_buffer_reader.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/output_buffer_reader.sv
// Drain engine for the RRAM output buffer: issues buffer reads for a host command and streams the words out through a skid FIFO.
// Optional checksum trailer word is enabled with `define OBR_CHECKSUM_EN.
module output_buffer_reader #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 7,
  parameter int RAM_DEPTH  = 64,
  parameter int SKID_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [ADDR_WIDTH-1:0] cmd_len,
  output logic                  buf_rd_cs,
  output logic                  buf_rd_en,
  output logic [ADDR_WIDTH-1:0] buf_rd_addr,
  input  logic [DATA_WIDTH-1:0] buf_rdata,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
  output logic                  busy,
  output logic                  done
);

  // state   | meaning
  // S_IDLE  | waiting for a command, cmd_ready high
  // S_ISSUE | issuing one buffer read per cycle while credit allows
  // S_DRAIN | all reads issued, waiting for the final word to be accepted
  // S_CSUM  | presenting the XOR checksum trailer (checksum build only)

  localparam int CW = $clog2(SKID_DEPTH + 1);
  localparam int PW = (SKID_DEPTH > 1) ? $clog2(SKID_DEPTH) : 1;
  localparam logic [CW:0]           SKID_LIMIT = (CW+1)'(SKID_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] ADDR_LAST  = ADDR_WIDTH'(RAM_DEPTH - 1);
  localparam logic [PW-1:0]         PTR_LAST   = PW'(SKID_DEPTH - 1);
  localparam logic [ADDR_WIDTH-1:0] REM_ONE    = ADDR_WIDTH'(1);

`ifdef OBR_CHECKSUM_EN
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_ISSUE = 2'd1, S_DRAIN = 2'd2, S_CSUM = 2'd3} state_t;
`else
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_ISSUE = 2'd1, S_DRAIN = 2'd2} state_t;
`endif

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [ADDR_WIDTH-1:0] r_rem;
  logic [ADDR_WIDTH-1:0] r_hold_addr;
  logic [1:0]            r_inflight;
  logic [1:0]            r_lastp;
  logic [DATA_WIDTH-1:0] r_skid_data [SKID_DEPTH];
  logic [SKID_DEPTH-1:0] r_skid_last;
  logic [PW-1:0]         r_wptr;
  logic [PW-1:0]         r_rptr;
  logic [CW-1:0]         r_count;
  logic                  r_done;
`ifdef OBR_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] r_csum;
`endif

  logic                  w_skid_nempty;
  logic [CW:0]           w_used;
  logic                  w_issue;
  logic                  w_push;
  logic                  w_pop;
  logic [DATA_WIDTH-1:0] w_head_data;
  logic                  w_head_last;
  logic [ADDR_WIDTH-1:0] w_addr_next;

  // Credit counts words already in the skid plus reads still in the buffer pipeline.
  assign w_skid_nempty = (r_count != '0);
  assign w_used        = {1'b0, r_count} + (CW+1)'(r_inflight[0]) + (CW+1)'(r_inflight[1]);
  assign w_issue       = (r_state == S_ISSUE) && (w_used < SKID_LIMIT);
  assign w_push        = r_inflight[1];
  assign w_pop         = w_skid_nempty && m_ready;
  assign w_head_data   = r_skid_data[r_rptr];
  assign w_head_last   = r_skid_last[r_rptr];
  assign w_addr_next   = (r_addr == ADDR_LAST) ? '0 : r_addr + 1'b1;

  assign buf_rd_cs   = w_issue || (r_inflight != 2'b00);
  assign buf_rd_en   = buf_rd_cs;
  assign buf_rd_addr = w_issue ? r_addr : r_hold_addr;

  assign cmd_ready = (r_state == S_IDLE);
  assign busy      = (r_state != S_IDLE);
  assign done      = r_done;

`ifdef OBR_CHECKSUM_EN
  assign m_valid = w_skid_nempty || (r_state == S_CSUM);
  assign m_data  = (r_state == S_CSUM) ? r_csum : (w_skid_nempty ? w_head_data : '0);
  assign m_last  = (r_state == S_CSUM);
`else
  assign m_valid = w_skid_nempty;
  assign m_data  = w_skid_nempty ? w_head_data : '0;
  assign m_last  = w_skid_nempty && w_head_last;
`endif

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_skid_data[r_wptr] <= buf_rdata;
      r_skid_last[r_wptr] <= r_lastp[1];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_addr      <= '0;
      r_rem       <= '0;
      r_hold_addr <= '0;
      r_inflight  <= 2'b00;
      r_lastp     <= 2'b00;
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_count     <= '0;
      r_done      <= 1'b0;
`ifdef OBR_CHECKSUM_EN
      r_csum      <= '0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (cmd_valid) begin
            if (cmd_len != '0) begin
              r_addr  <= cmd_addr;
              r_rem   <= cmd_len;
              r_state <= S_ISSUE;
            end else begin
              r_done <= 1'b1;
            end
          end
        end
        S_ISSUE: begin
          if (w_issue) begin
            r_addr <= w_addr_next;
            r_rem  <= r_rem - 1'b1;
            if (r_rem == REM_ONE) r_state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          // The final word is the last one issued, so the pipeline is empty once it pops.
          if (w_pop && w_head_last && (r_inflight == 2'b00)) begin
`ifdef OBR_CHECKSUM_EN
            r_state <= S_CSUM;
`else
            r_done  <= 1'b1;
            r_state <= S_IDLE;
`endif
          end
        end
`ifdef OBR_CHECKSUM_EN
        S_CSUM: begin
          if (m_ready) begin
            r_done  <= 1'b1;
            r_state <= S_IDLE;
          end
        end
`endif
        default: r_state <= S_IDLE;
      endcase

      r_inflight <= {r_inflight[0], w_issue};
      r_lastp    <= {r_lastp[0], w_issue && (r_rem == REM_ONE)};
      if (w_issue) r_hold_addr <= r_addr;

      if (w_push) r_wptr <= (r_wptr == PTR_LAST) ? '0 : r_wptr + 1'b1;
      if (w_pop)  r_rptr <= (r_rptr == PTR_LAST) ? '0 : r_rptr + 1'b1;
      if (w_push && !w_pop)      r_count <= r_count + 1'b1;
      else if (!w_push && w_pop) r_count <= r_count - 1'b1;

`ifdef OBR_CHECKSUM_EN
      if ((r_state == S_IDLE) && cmd_valid) r_csum <= '0;
      else if (w_pop)                       r_csum <= r_csum ^ w_head_data;
`endif
    end
  end

endmodule

// File: tb/tb_output_buffer_reader.sv
// Self-checking bench for output_buffer_reader: buffer RAM model, transaction-level stream model and directed commands.
module tb_output_buffer_reader;
  localparam int DW = 32;
  localparam int AW = 7;
  localparam int DEPTH = 64;
  localparam int SD = 4;
`ifdef OBR_CHECKSUM_EN
  localparam int CSUM = 1;
`else
  localparam int CSUM = 0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [AW-1:0] cmd_addr = '0;
  logic [AW-1:0] cmd_len = '0;
  logic          buf_rd_cs, buf_rd_en;
  logic [AW-1:0] buf_rd_addr;
  logic [DW-1:0] buf_rdata = '0;
  logic          m_valid;
  logic          m_ready = 1'b1;
  logic [DW-1:0] m_data;
  logic          m_last, busy, done;

  always #5 clk = ~clk;

  output_buffer_reader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RAM_DEPTH(DEPTH), .SKID_DEPTH(SD)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .buf_rd_cs(buf_rd_cs), .buf_rd_en(buf_rd_en),
    .buf_rd_addr(buf_rd_addr), .buf_rdata(buf_rdata), .m_valid(m_valid), .m_ready(m_ready),
    .m_data(m_data), .m_last(m_last), .busy(busy), .done(done)
  );

  // Buffer with a two-stage read pipeline: pointer load, then registered data.
  logic [DW-1:0] mem [DEPTH];
  logic [5:0]    ptr = '0;
  always @(posedge clk) begin
    if (buf_rd_cs && buf_rd_en) begin
      ptr       <= buf_rd_addr[5:0];
      buf_rdata <= mem[ptr];
    end
  end

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Transaction-level model of the current command.
  int  exp_start = 0, exp_len = 0, k = 0, issued = 0;
  bit  active = 0, pend_done = 0, stalled = 0, stall_last = 0;
  logic [DW-1:0] stall_data = '0;
  logic [DW-1:0] got_q[$];

  function automatic int total_words();
    return (exp_len == 0) ? 0 : exp_len + CSUM;
  endfunction

  function automatic logic [DW-1:0] exp_word(input int idx);
    logic [DW-1:0] x;
    x = '0;
    if (idx < exp_len) return mem[(exp_start + idx) % DEPTH];
    for (int i = 0; i < exp_len; i++) x ^= mem[(exp_start + i) % DEPTH];
    return x;
  endfunction

  function automatic bit exp_last(input int idx);
    return (CSUM != 0) ? (idx == exp_len) : (idx == exp_len - 1);
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      check("rst_ctrl", 32'({buf_rd_addr, buf_rd_en, buf_rd_cs, m_last, m_valid, done, busy, cmd_ready}), 32'h1);
      check("rst_data", m_data, '0);
      active = 0; pend_done = 0; stalled = 0; issued = 0; k = 0;
    end else begin
      check("done", 32'(done), 32'(pend_done));
      pend_done = 0;
      check("busy", 32'(busy), 32'(active));
      check("cmd_ready", 32'(cmd_ready), 32'(!active));
      check("cs_en", 32'(buf_rd_cs), 32'(buf_rd_en));
      if (!active) check("idle_quiet", 32'({m_valid, buf_rd_en}), 32'h0);
      if (stalled) begin
        check("hold_ctl", 32'({m_valid, m_last}), 32'({1'b1, stall_last}));
        check("hold_data", m_data, stall_data);
      end
      if (active && buf_rd_en && issued < exp_len && int'(buf_rd_addr) == (exp_start + issued) % DEPTH)
        issued++;
      if (m_valid && m_ready) begin
        if (!active || k >= total_words()) begin
          check("extra_word", m_data, '0);
          check("extra_word_valid", 32'(m_valid), 32'h0);
        end else begin
          check("data", m_data, exp_word(k));
          check("last", 32'(m_last), 32'(exp_last(k)));
          got_q.push_back(m_data);
          k++;
          if (k == total_words()) begin
            check("addr_seq", issued, exp_len);
            active = 0;
            pend_done = 1;
          end
        end
      end
      if (active) begin
        int kd;
        kd = (k < exp_len) ? k : exp_len;
        if (issued - kd > SD) check("outstanding", issued - kd, SD);
        else checks++;
      end
      stalled = m_valid && !m_ready;
      stall_data = m_data;
      stall_last = m_last;
      if (cmd_valid && cmd_ready) begin
        exp_start = int'(cmd_addr);
        exp_len = int'(cmd_len);
        k = 0;
        issued = 0;
        if (exp_len == 0) pend_done = 1;
        else active = 1;
      end
    end
  end

  task automatic finish_now();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  endtask

  task automatic send(input int addr, input int len);
    @(posedge clk); #1;
    cmd_valid = 1'b1;
    cmd_addr = AW'(addr);
    cmd_len = AW'(len);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int n;
    n = 0;
    while (active && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    if (active) begin
      errors++; checks++;
      $display("FAIL %s: timeout after %0d cycles", name, budget);
      finish_now();
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic check_list(input string name, input logic [DW-1:0] exp[], input int n);
    check({name, "_count"}, got_q.size(), n + CSUM);
    for (int i = 0; i < n; i++) check(name, (i < got_q.size()) ? got_q[i] : 32'hDEAD_BEEF, exp[i]);
  endtask

  initial begin
    logic [DW-1:0] e[];
    int n;
    for (int i = 0; i < DEPTH; i++) mem[i] = 32'hA000_0000 + DW'(i);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);

    // Basic read of four words
    got_q.delete(); m_ready = 1'b1;
    send(5, 4);
    wait_done("basic", 100);
    e = new[4]; e = '{32'hA000_0005, 32'hA000_0006, 32'hA000_0007, 32'hA000_0008};
    check_list("basic", e, 4);

    // Address wrap at the end of the buffer
    got_q.delete();
    send(62, 4);
    wait_done("wrap", 100);
    e = '{32'hA000_003E, 32'hA000_003F, 32'hA000_0000, 32'hA000_0001};
    check_list("wrap", e, 4);

    // Backpressure with a command attempted while busy
    got_q.delete();
    send(0, 16);
    n = 0;
    while (active && n < 400) begin
      @(posedge clk); #1;
      m_ready = (n >= 10 && n < 20) ? 1'b0 : ((n % 3) == 0);
      cmd_valid = (n == 5);
      cmd_addr = AW'(33);
      cmd_len = AW'(3);
      n++;
    end
    cmd_valid = 1'b0;
    m_ready = 1'b1;
    if (active) begin
      errors++; checks++;
      $display("FAIL backpressure: timeout after %0d cycles", n);
      finish_now();
    end
    repeat (2) @(posedge clk);
    #1;
    check("bp_count", got_q.size(), 16 + CSUM);
    check("bp_first", got_q[0], 32'hA000_0000);
    check("bp_last", got_q[15], 32'hA000_000F);

    // Null command
    send(20, 0);
    n = int'(done);
    repeat (5) begin
      @(posedge clk); #1;
      n += int'(done);
    end
    check("null_done_pulses", n, 1);
    check("null_cmd_ready", 32'(cmd_ready), 32'h1);

    // Reset in the middle of a stalled burst
    m_ready = 1'b0;
    send(0, 8);
    n = 0;
    while (issued < 3 && n < 50) begin
      @(posedge clk);
      n++;
    end
    check("rst_issued", 32'(issued >= 3), 32'h1);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    check("mid_rst_ready", 32'({cmd_ready, m_valid, buf_rd_en}), 32'h4);
    @(posedge clk); #1;
    rst = 1'b1;
    m_ready = 1'b1;
    repeat (3) @(posedge clk);
    got_q.delete();
    send(10, 2);
    wait_done("after_reset", 100);
    e = new[2]; e = '{32'hA000_000A, 32'hA000_000B};
    check_list("after_reset", e, 2);

`ifdef OBR_CHECKSUM_EN
    got_q.delete();
    send(1, 3);
    wait_done("csum", 100);
    e = new[3]; e = '{32'hA000_0001, 32'hA000_0002, 32'hA000_0003};
    check_list("csum", e, 3);
    check("csum_word", got_q[3], 32'hA000_0000);
`endif

    finish_now();
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1);
  end

endmodule
